// File: rtl/seg_pkg.sv
// seg_pkg: shared digit constants and types for the seven-segment scan driver
package seg_pkg;
    localparam int NUM_DIGITS = 3;
    localparam int SEG_W = 4;
    localparam logic [2:0] EN_ALL_OFF = 3'b111;
    localparam logic [2:0] EN_DIG0 = 3'b110;
    localparam logic [2:0] EN_DIG1 = 3'b101;
    localparam logic [2:0] EN_DIG2 = 3'b011;
    typedef enum logic [1:0] {DIG0, DIG1, DIG2} dig_t;
    function automatic logic [2:0] dig_enable(input logic [1:0] d);
        return d == 2'd2 ? EN_DIG2 : d == 2'd1 ? EN_DIG1 : EN_DIG0;
    endfunction
endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot/digit prescaler producing slot, frame and guard timing
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 2000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] dig_nxt_o,
    output logic       slot_end_o,
    output logic       frame_end_o,
    output logic       in_guard_o
);
    localparam int CW = $clog2(SCAN_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    dig_t dig_q, dig_d;
    // dig_nxt_o and in_guard_o describe the cycle being entered, so outputs can be registered
    always_comb begin
        slot_end_o  = cnt_q == CW'(SCAN_DIV - 1);
        frame_end_o = slot_end_o && dig_q == dig_t'(NUM_DIGITS - 1);
        cnt_d       = slot_end_o ? '0 : cnt_q + 1'b1;
        dig_d       = !slot_end_o ? dig_q : frame_end_o ? DIG0 : dig_t'(dig_q + 2'd1);
        dig_nxt_o   = dig_d;
        in_guard_o  = cnt_d < CW'(GUARD);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            dig_q <= DIG0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
        end
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 3-digit multiplexed display driver with frame-aligned loads and blanking
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [11:0] load_data,
    output logic        load_ready,
    input  logic        lz_blank,
    output logic [3:0]  digit_out,
    output logic [2:0]  SevenSegmentEnable,
    output logic        frame_start
);
    logic [1:0] dig_nxt;
    logic slot_end, frame_end, in_guard, xfer, blank;
    logic [11:0] shadow_q, shadow_d, active_q, active_d;
    logic pending_q, pending_d, ready_q, ready_d, fs_q, fs_d;
    logic [SEG_W-1:0] digit_q, digit_d;
    logic [2:0] en_q, en_d;
    seg_scan_timer #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .dig_nxt_o  (dig_nxt),
        .slot_end_o (slot_end),
        .frame_end_o(frame_end),
        .in_guard_o (in_guard)
    );
    // a value accepted on the last cycle of a frame bypasses the shadow straight into slot 0
    always_comb begin
        xfer      = load_valid && ready_q;
        shadow_d  = xfer ? load_data : shadow_q;
        active_d  = !frame_end ? active_q : xfer ? load_data : pending_q ? shadow_q : active_q;
        pending_d = !frame_end && (pending_q || xfer);
        ready_d   = frame_end || (ready_q && !xfer);
        digit_d   = dig_nxt == 2'd2 ? active_d[11:8] : dig_nxt == 2'd1 ? active_d[7:4] : active_d[3:0];
        blank     = lz_blank && (dig_nxt == 2'd2 ? active_d[11:8] == '0 :
                                 dig_nxt == 2'd1 ? active_d[11:4] == '0 : 1'b0);
        en_d      = (in_guard || blank) ? EN_ALL_OFF : dig_enable(dig_nxt);
        fs_d      = slot_end && dig_nxt == 2'd0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            digit_q   <= '0;
            en_q      <= EN_ALL_OFF;
            fs_q      <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            digit_q   <= digit_d;
            en_q      <= en_d;
            fs_q      <= fs_d;
        end
    end
    assign load_ready         = ready_q;
    assign digit_out          = digit_q;
    assign SevenSegmentEnable = en_q;
    assign frame_start        = fs_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized scoreboard bench against a frame-timing reference model
module tb_seg_scan_driver;
    localparam int SD = 8, G = 2, FR = 3 * SD;
    logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0, lz_blank = 1'b0;
    logic [11:0] load_data = '0;
    logic load_ready, frame_start;
    logic [3:0] digit_out;
    logic [2:0] SevenSegmentEnable;
    int checks = 0, failures = 0, t = 0, n = 0;
    typedef struct {int t; logic [3:0] dg; logic [2:0] en; logic fs; logic rdy;} exp_t;
    exp_t exp_q[$];
    exp_t e;
    int acc_t[$];
    logic [11:0] acc_v[$];

    seg_scan_driver #(.SCAN_DIV(SD), .GUARD(G)) dut (
        .clk               (clk),
        .rst               (rst),
        .load_valid        (load_valid),
        .load_data         (load_data),
        .load_ready        (load_ready),
        .lz_blank          (lz_blank),
        .digit_out         (digit_out),
        .SevenSegmentEnable(SevenSegmentEnable),
        .frame_start       (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int tt, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", name, tt, act, exp);
        end
    endtask

    // Displayed value: the latest accepted value from before the current frame began.
    function automatic logic [11:0] active_at(int tt);
        logic [11:0] v = '0;
        foreach (acc_t[i]) if (acc_t[i] < (tt / FR) * FR) v = acc_v[i];
        return v;
    endfunction

    // Ready unless something was already accepted within the current frame.
    function automatic bit ready_at(int tt);
        foreach (acc_t[i]) if (acc_t[i] >= (tt / FR) * FR && acc_t[i] < tt) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t expect_at(int tt, bit lz);
        exp_t x;
        logic [11:0] a = active_at(tt);
        int d = (tt / SD) % 3;
        bit blank = lz && ((d == 2 && a[11:8] == 0) || (d == 1 && a[11:4] == 0));
        x.t   = tt;
        x.dg  = 4'(a >> (4 * d));
        x.en  = (tt % SD < G || blank) ? 3'b111 : 3'b111 ^ 3'(1 << d);
        x.fs  = tt > 0 && tt % FR == 0;
        x.rdy = ready_at(tt);
        return x;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            t = 0;
            acc_t.delete();
            acc_v.delete();
            exp_q.delete();
        end else begin
            if (load_valid && ready_at(t)) begin
                acc_t.push_back(t);
                acc_v.push_back(load_data);
            end
            t++;
            exp_q.push_back(expect_at(t, lz_blank));
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("digit_out", e.t, digit_out, e.dg);
            chk("enable", e.t, SevenSegmentEnable, e.en);
            chk("frame_start", e.t, frame_start, e.fs);
            chk("load_ready", e.t, load_ready, e.rdy);
            chk("one_enable_low", e.t, $countones(~SevenSegmentEnable) <= 1, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic frames(int k);
        repeat (k * FR) tick();
    endtask

    task automatic load(logic [11:0] v);
        load_valid = 1'b1;
        load_data  = v;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_phase(int p);
        int i = 0;
        while (t % FR != p && i < 4 * FR) begin
            tick();
            i++;
        end
        chk("wait_phase", t, t % FR, p);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_en"}, -1, SevenSegmentEnable, 3'b111);
        chk({tag, "_digit"}, -1, digit_out, 0);
        chk({tag, "_ready"}, -1, load_ready, 1);
        chk({tag, "_fs"}, -1, frame_start, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        for (int i = 1; i <= 2 * FR && n == 0; i++) begin
            tick();
            if (frame_start) n = i;
        end
        chk("first_frame_start", t, n, FR);

        wait_phase(11);
        load(12'hA3C);
        chk("ready_drop", t, load_ready, 0);
        frames(2);

        wait_phase(3);
        load_valid = 1'b1;
        load_data  = 12'h111;
        tick();
        load_data  = 12'h222;
        repeat (FR) tick();
        load_valid = 1'b0;
        frames(2);

        lz_blank = 1'b1;
        load(12'h005);
        frames(2);
        load(12'h000);
        frames(2);
        lz_blank = 1'b0;
        frames(2);

        for (int i = 0; i < 12 * FR; i++) begin
            load_valid = $urandom_range(3) == 0;
            load_data  = 12'($urandom);
            if ($urandom_range(15) == 0) lz_blank = ~lz_blank;
            tick();
        end
        load_valid = 1'b0;
        lz_blank   = 1'b0;
        frames(1);
        load(12'h4B7);
        frames(2);

        wait_phase(2);
        load(12'h777);
        wait_phase(10);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        repeat (2) tick();
        rst = 1'b0;
        frames(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver for the board's 3-digit common-anode seven-segment display, sitting directly upstream of the per-digit hex-to-segment decoder. It holds a 12-bit value (three hex nibbles), cycles through the digits at a programmable refresh rate, and presents one nibble plus the matching active-low digit enable each slot. New values are taken through a valid/ready handshake and applied only at frame boundaries, so the display never shows a torn value. Optional leading-zero blanking and an inter-digit guard time suppress ghosting.

## Interface
- SCAN_DIV, default 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Must be ≥ GUARD+2.
- GUARD, default 2000: cycles at the start of each slot with all digits disabled. Must be < SCAN_DIV.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  12  value to display; [3:0] rightmost digit, [11:8] leftmost.
- load_ready  output  1  driver can accept a value.
- lz_blank  input  1  1 = suppress leading zeros.
- digit_out  output  4  nibble for the decoder.
- SevenSegmentEnable  output  3  active-low digit enables; bit 0 = rightmost digit.
- frame_start  output  1  one-cycle pulse when slot 0 of a new frame begins.

## Operation
- Registers: shadow[11:0], pending, active[11:0], slot counter cnt (0..SCAN_DIV-1), digit index dig (0,1,2).
- Reset values: active=0, shadow=0, pending=0, cnt=0, dig=0, load_ready=1, digit_out=0, SevenSegmentEnable=3'b111, frame_start=0.
- Handshake: a transfer occurs on a cycle with load_valid && load_ready. Next cycle: shadow=load_data, pending=1, load_ready=0. load_ready stays 0 until the value is applied. load_valid without load_ready is ignored; load_data need not be held.
- Scan: cnt increments every cycle; at cnt==SCAN_DIV-1, cnt wraps to 0 and dig advances 0→1→2→0.
- Frame boundary: the wrap with dig==2→0. On that edge, if pending: active=shadow, pending=0, load_ready=1, and the new value is used for slot 0 immediately. frame_start=1 for the first cycle of that slot.
- Outputs, registered: digit_out = active nibble dig. SevenSegmentEnable = 3'b111 while cnt<GUARD or digit dig is blanked; otherwise it is all ones except bit dig=0 (slot 0 → 3'b110, slot 1 → 3'b101, slot 2 → 3'b011).
- Blanking with lz_blank=1: digit 2 is blanked if active[11:8]==0. Digit 1 is blanked if active[11:4]==0. Digit 0 is never blanked, so 0x000 shows "0". With lz_blank=0, nothing is blanked. lz_blank is sampled every cycle and takes effect at once.
- Reset asserted mid-frame or with a pending value: all state returns to reset values, and the pending value is lost.

## Timing
- Each output depends on registered state at the cycle before.
- Load-to-display latency is ≤ 3·SCAN_DIV+1 cycles. Best case is 1 cycle, when accepted on the last cycle of slot 2.
- Frame period is exactly 3·SCAN_DIV cycles. frame_start period is the same.
- At most one enable bit is low in any cycle. The guard keeps all enables high for GUARD cycles at every slot change.
- load_ready rises on the same edge that active updates, so the earliest next acceptance is the first cycle of slot 0.

## Structure
- Shared package seg_pkg:
  - NUM_DIGITS=3
  - EN_ALL_OFF=3'b111
  - per-digit enable constants
  - digit-index type
  - the seven-segment decoder's input width (4)
- One sub-module: seg_scan_timer. It contains the cnt/dig prescaler and emits slot_end, frame_end and in_guard. seg_scan_driver contains the handshake, shadow/active registers, blanking logic and output registers.

## Test plan
Bench parameters: SCAN_DIV=8, GUARD=2.
- Reset: hold rst for 3 cycles, then release. Required: SevenSegmentEnable=3'b111, digit_out=0, load_ready=1. First frame_start occurs 24 cycles after release. Slot 0 shows enable 3'b110 from cnt 2 to 7.
- Load 0xA3C mid-slot 1. Required: load_ready drops the next cycle. active stays 0 until the slot 2→0 wrap. Then digit_out is C, 3, A in slots 0, 1, 2, with enables 110/101/011 after 2 guard cycles each.
- Back-to-back: load_valid held high with 0x111, then 0x222. Required: only 0x111 is accepted. 0x222 is accepted on the first cycle of the following slot 0 and displayed one frame later.
- Leading zeros: active=0x005 with lz_blank=1. Required: slots 1 and 2 keep 3'b111 throughout, and slot 0 shows 5. With active=0x000, only digit 0 is lit, showing 0. With lz_blank=0, all three digits are lit.
- Reset mid-operation: assert rst while pending=1 in slot 1. Required: all outputs return to reset values asynchronously, and the old active value is not displayed after release.
- Guard and exclusivity: across 10 frames, assert that at most one enable bit is low in every cycle, and that enables are 3'b111 for exactly 2 cycles at each slot start.
